// File: rtl/assoc_cache.sv
// assoc_cache: 2-way set-associative, write-back, write-allocate cache with
// true-LRU replacement, between a 32-bit word processor port and a 128-bit
// line memory port.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   proc_reset   synchronous active-high reset
//   proc_read    read request, held until proc_stall is low
//   proc_write   write request, held until proc_stall is low (wins over read)
//   proc_addr    word address: [1:0] word, [SET_BITS+1:2] index, rest tag
//   proc_wdata   write data
//   proc_stall   request not yet complete
//   proc_rdata   read data, valid when proc_read & !proc_stall
//   mem_read     line fill request
//   mem_write    line write-back request
//   mem_addr     line address {tag,index}
//   mem_wdata    victim line, word k at [32k+31:32k]
//   mem_rdata    fill line, same packing
//   mem_ready    one-cycle completion pulse for the current mem request
//   o_dbg_state  current FSM state (0 COMPARE, 1 WRITEBACK, 2 ALLOCATE)
//
// Handshakes: the processor presents a request and holds address/data
// stable until it sees proc_stall low in a cycle; the access completes at
// the following rising edge. Towards memory, mem_read/mem_write and mem_addr/
// mem_wdata are decoded from the state register and stay stable until the
// cycle in which mem_ready is sampled high; mem_ready at any other time is
// ignored.
module assoc_cache #(
  parameter int ADDR_W   = 30,
  parameter int SET_BITS = 3
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic              proc_stall,
  output logic [31:0]       proc_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        o_dbg_state
);

  localparam int TAG_W = ADDR_W - 2 - SET_BITS;
  localparam int SETS  = 1 << SET_BITS;

  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Per set: bit w of r_valid/r_dirty belongs to way w.
  logic [1:0]       r_valid [SETS];
  logic [1:0]       r_dirty [SETS];
  logic [SETS-1:0]  r_lru;              // 1 = way1 is least recently used
  logic [TAG_W-1:0] r_tag   [2][SETS];
  logic [127:0]     r_data  [2][SETS];
  logic             r_victim;

  logic [SET_BITS-1:0] w_index;
  logic [TAG_W-1:0]    w_tag;
  logic [6:0]          w_word_lsb;
  logic                w_req;
  logic [1:0]          w_way_hit;
  logic                w_hit;
  logic                w_hit_way;
  logic                w_victim;
  logic                w_victim_dirty;

  assign w_index    = proc_addr[SET_BITS+1:2];
  assign w_tag      = proc_addr[ADDR_W-1:SET_BITS+2];
  assign w_word_lsb = {proc_addr[1:0], 5'b0};
  assign w_req      = proc_read | proc_write;

  always_comb begin
    w_way_hit = 2'b00;
    for (int w = 0; w < 2; w++) begin
      w_way_hit[w] = r_valid[w_index][w] && (r_tag[w][w_index] == w_tag);
    end
  end

  assign w_hit     = |w_way_hit;
  assign w_hit_way = w_way_hit[1];

  // Fill an empty way before evicting anything; otherwise evict the LRU way.
  assign w_victim = !r_valid[w_index][0] ? 1'b0 :
                    !r_valid[w_index][1] ? 1'b1 : r_lru[w_index];
  assign w_victim_dirty = r_valid[w_index][w_victim] && r_dirty[w_index][w_victim];

  // State register
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state <= S_COMPARE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_COMPARE: begin
        if (w_req && !w_hit) begin
          w_next_state = w_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) w_next_state = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        if (mem_ready) w_next_state = S_COMPARE;
      end
      default: w_next_state = S_COMPARE;
    endcase
  end

  // Output logic
  always_comb begin
    proc_stall  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = proc_addr[ADDR_W-1:2];
    mem_wdata   = r_data[r_victim][w_index];
    proc_rdata  = r_data[w_hit_way][w_index][w_word_lsb +: 32];
    o_dbg_state = r_state;
    if (!proc_reset) begin
      proc_stall = (r_state != S_COMPARE) || (w_req && !w_hit);
    end
    case (r_state)
      S_WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {r_tag[r_victim][w_index], w_index};
      end
      S_ALLOCATE: begin
        mem_read = 1'b1;
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  // Valid / dirty / LRU bookkeeping and victim latch
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= 2'b00;
        r_dirty[s] <= 2'b00;
      end
      r_lru    <= '0;
      r_victim <= 1'b0;
    end else begin
      case (r_state)
        S_COMPARE: begin
          if (w_req && w_hit) begin
            r_lru[w_index] <= ~w_hit_way;
            if (proc_write) r_dirty[w_index][w_hit_way] <= 1'b1;
          end else if (w_req) begin
            r_victim <= w_victim;
          end
        end
        S_ALLOCATE: begin
          if (mem_ready) begin
            r_valid[w_index][r_victim] <= 1'b1;
            r_dirty[w_index][r_victim] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays are never cleared; valid bits guard them.
  // A write miss lands here twice: the fill, then the merge on the re-compare hit.
  always_ff @(posedge clk) begin
    if (!proc_reset) begin
      if (r_state == S_ALLOCATE && mem_ready) begin
        r_data[r_victim][w_index] <= mem_rdata;
        r_tag[r_victim][w_index]  <= w_tag;
      end else if (r_state == S_COMPARE && proc_write && w_hit) begin
        r_data[w_hit_way][w_index][w_word_lsb +: 32] <= proc_wdata;
      end
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Testbench for assoc_cache: table of accesses with hand-derived miss /
// write-back / latency expectations, a reference word model feeding an
// expected-read-data queue, a next-level memory model, and hand sequences
// for reset during a fill and for random traffic.
module tb_assoc_cache;

  logic         clk;
  logic         proc_reset;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [1:0]   o_dbg_state;

  assoc_cache #(.ADDR_W(30), .SET_BITS(3)) dut (
    .clk         (clk),
    .proc_reset  (proc_reset),
    .proc_read   (proc_read),
    .proc_write  (proc_write),
    .proc_addr   (proc_addr),
    .proc_wdata  (proc_wdata),
    .proc_stall  (proc_stall),
    .proc_rdata  (proc_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  ref_words [int];   // latest processor-written value per word
  logic [127:0] mem_lines [int];   // next-level memory contents per line
  int fill_delay = 3;
  int wb_delay   = 2;
  int mem_cnt    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] backing_line(input int la);
    logic [127:0] l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int k = 0; k < 4; k++) l[32*k +: 32] = 32'hA000_0000 | 32'(la << 4) | 32'(k);
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    logic [127:0] l;
    if (ref_words.exists(a)) return ref_words[a];
    l = backing_line(a >> 2);
    return l[32*(a & 3) +: 32];
  endfunction

  function automatic logic [127:0] ref_line(input int la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = ref_word(la * 4 + k);
    return l;
  endfunction

  // ---------------- next-level memory model ----------------
  // Counts request cycles and pulses mem_ready in the fill_delay-th / wb_delay-th one.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (proc_reset || !(mem_read || mem_write)) begin
      mem_cnt = 0;
    end else begin
      mem_cnt++;
      if (mem_cnt >= (mem_write ? wb_delay : fill_delay)) begin
        mem_cnt   = 0;
        mem_ready = 1'b1;
        if (mem_write) begin
          check($sformatf("wb_data@%0h", mem_addr), mem_wdata, ref_line(int'(mem_addr)));
          mem_lines[int'(mem_addr)] = mem_wdata;
        end else begin
          mem_rdata = backing_line(int'(mem_addr));
        end
      end
    end
  end

  // ---------------- driver ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        chk_mem;
    logic        exp_miss;
    logic        exp_wb;
    logic [27:0] exp_fill;
    logic [27:0] exp_wb_addr;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [29:0] addr,
                              input logic [31:0] wdata, input logic miss, input logic wb,
                              input logic [27:0] fill, input logic [27:0] wba);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.chk_mem = 1'b1;
    v.exp_miss = miss; v.exp_wb = wb; v.exp_fill = fill; v.exp_wb_addr = wba;
    return v;
  endfunction

  // Called just after a rising edge; returns just after the edge that completes the access.
  task automatic do_access(input string tag, input vec_t v);
    int          cycles;
    int          exp_cycles;
    logic        saw_fill, saw_wb, both, unstable;
    logic [27:0] f_addr, w_addr;
    cycles = 0; saw_fill = 0; saw_wb = 0; both = 0; unstable = 0;
    f_addr = '0; w_addr = '0;
    proc_read = v.rd; proc_write = v.wr; proc_addr = v.addr; proc_wdata = v.wdata;
    if (v.rd && !v.wr) exp_q.push_back(ref_word(int'(v.addr)));
    forever begin
      @(negedge clk);
      cycles++;
      if (mem_read && mem_write) both = 1;
      if (mem_read) begin
        if (saw_fill && mem_addr !== f_addr) unstable = 1;
        saw_fill = 1; f_addr = mem_addr;
      end
      if (mem_write) begin
        if (saw_wb && mem_addr !== w_addr) unstable = 1;
        saw_wb = 1; w_addr = mem_addr;
      end
      if (!proc_stall || cycles >= 300) break;
    end
    check({tag, "_stall_release"}, proc_stall, 1'b0);
    if (v.rd && !v.wr) check({tag, "_rdata"}, proc_rdata, exp_q.pop_front());
    check({tag, "_mem_exclusive"}, both, 1'b0);
    check({tag, "_mem_addr_stable"}, unstable, 1'b0);
    if (v.chk_mem) begin
      check({tag, "_miss"}, saw_fill, v.exp_miss);
      check({tag, "_wb"}, saw_wb, v.exp_wb);
      if (v.exp_miss) check({tag, "_fill_addr"}, f_addr, v.exp_fill);
      if (v.exp_wb) check({tag, "_wb_addr"}, w_addr, v.exp_wb_addr);
      // Cycles with the request presented, including the completing cycle.
      exp_cycles = v.exp_miss ? (2 + fill_delay + (v.exp_wb ? wb_delay : 0)) : 1;
      check({tag, "_latency"}, cycles, exp_cycles);
    end
    if (v.wr) ref_words[int'(v.addr)] = v.wdata;
    @(posedge clk);
    #1;
    proc_read = 1'b0;
    proc_write = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t vecs[15];
  vec_t post[3];

  initial begin
    logic seen;
    vec_t rv;
    int   op;

    // Set 4, way contents derived by hand (LRU = way not most recently hit).
    vecs[0]  = mk(1, 0, 30'h10, 32'h0,         1, 0, 28'h4,  28'h0); // cold fill way0
    vecs[1]  = mk(0, 1, 30'h11, 32'hDEADBEEF,  0, 0, 28'h0,  28'h0); // write hit, dirty
    vecs[2]  = mk(1, 0, 30'h11, 32'h0,         0, 0, 28'h0,  28'h0);
    vecs[3]  = mk(1, 0, 30'h30, 32'h0,         1, 0, 28'hC,  28'h0); // fill way1 (invalid)
    vecs[4]  = mk(1, 0, 30'h10, 32'h0,         0, 0, 28'h0,  28'h0); // LRU -> way1
    vecs[5]  = mk(1, 0, 30'h50, 32'h0,         1, 0, 28'h14, 28'h0); // evict clean tag1
    vecs[6]  = mk(1, 0, 30'h50, 32'h0,         0, 0, 28'h0,  28'h0); // LRU -> way0
    vecs[7]  = mk(1, 0, 30'h70, 32'h0,         1, 1, 28'h1C, 28'h4); // evict dirty tag0
    vecs[8]  = mk(1, 0, 30'h10, 32'h0,         1, 0, 28'h4,  28'h0); // evict clean tag2
    vecs[9]  = mk(1, 0, 30'h11, 32'h0,         0, 0, 28'h0,  28'h0); // written-back data
    vecs[10] = mk(1, 1, 30'h12, 32'h5A5A5A5A,  0, 0, 28'h0,  28'h0); // rd+wr acts as write
    vecs[11] = mk(1, 0, 30'h12, 32'h0,         0, 0, 28'h0,  28'h0);
    vecs[12] = mk(0, 1, 30'h04, 32'h12345678,  1, 0, 28'h1,  28'h0); // write-allocate
    vecs[13] = mk(1, 0, 30'h04, 32'h0,         0, 0, 28'h0,  28'h0);
    vecs[14] = mk(1, 0, 30'h07, 32'h0,         0, 0, 28'h0,  28'h0);

    post[0]  = mk(1, 0, 30'h10, 32'h0,         1, 0, 28'h4,  28'h0); // valid cleared
    post[1]  = mk(1, 0, 30'h12, 32'h0,         0, 0, 28'h0,  28'h0); // dirty 5A5A lost
    post[2]  = mk(1, 0, 30'h04, 32'h0,         1, 0, 28'h1,  28'h0);

    mem_lines[4] = 128'h33333333_22222222_11111111_00000000;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    proc_reset = 1'b1;

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = 30'h10;
    #1;
    check("rst_stall", proc_stall, 1'b0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_state", o_dbg_state, 2'd0);
    @(posedge clk);
    #1;
    proc_reset = 1'b0;
    proc_read  = 1'b0;
    @(negedge clk);
    check("idle_stall", proc_stall, 1'b0);
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 15; i++) do_access($sformatf("v%0d", i), vecs[i]);

    // Random traffic on sets 1 and 2, four tags each, with varying memory delays
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      rv = mk(op < 2, op >= 2, 30'(($urandom_range(0, 3) << 5) | ($urandom_range(1, 2) << 2) |
              $urandom_range(0, 3)), $urandom, 0, 0, 28'h0, 28'h0);
      rv.chk_mem = 1'b0;
      if (op == 3) rv.rd = 1'b1;
      fill_delay = $urandom_range(1, 4);
      wb_delay   = $urandom_range(1, 3);
      do_access($sformatf("r%0d", i), rv);
    end
    fill_delay = 3;
    wb_delay   = 2;

    // Reset while a fill is outstanding
    fill_delay = 40;
    proc_read  = 1'b1;
    proc_addr  = 30'h90;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_read) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid_reached_fill", seen, 1'b1);
    @(posedge clk);
    #1;
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    @(negedge clk);
    check("rst_mid_stall", proc_stall, 1'b0);
    @(posedge clk);
    #1;
    proc_reset = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_read", mem_read, 1'b0);
    check("rst_mid_mem_write", mem_write, 1'b0);
    check("rst_mid_state", o_dbg_state, 2'd0);
    ref_words.delete();   // dirty lines still in the cache are gone
    fill_delay = 3;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) do_access($sformatf("p%0d", i), post[i]);

    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
